// File: rtl/axil_req_arbiter_if.sv
// axil_req_arbiter_if: AXI-lite master bus carried between the request
// arbiter and the register-file slave port. Signal names match the
// arbiter's m_* bus so existing hookups map one-to-one.
interface axil_req_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [2:0]              m_awprot;
    logic                    m_awvalid;
    logic                    m_awready;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wvalid;
    logic                    m_wready;
    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;
    logic [ADDR_WIDTH-1:0]   m_araddr;
    logic [2:0]              m_arprot;
    logic                    m_arvalid;
    logic                    m_arready;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rvalid;
    logic                    m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arprot, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awprot, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arprot, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );
endinterface

// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter: round-robin arbiter sharing one AXI-lite master port
// between NUM_REQ command sources, one transaction outstanding at a time.
// Optional watchdog: define AXIL_TIMEOUT_EN to abort a stalled handshake
// after TIMEOUT_CYCLES cycles (resp=2'b11, rdata=DEAD_BEEF, sticky
// timeout_err).
module axil_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            aclk,
    input  logic                            aclk_reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [1:0]                      req_resp,
    axil_req_arbiter_if.master              m,
    output logic                            busy
`ifdef AXIL_TIMEOUT_EN
    ,
    output logic                            timeout_err
`endif
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("axil_req_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_ACK
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [GW-1:0]         r_rr;
    logic [GW-1:0]         r_grant;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]         r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;
    logic                  r_busy;

    logic                  w_hi_found;
    logic                  w_lo_found;
    logic [GW-1:0]         w_hi;
    logic [GW-1:0]         w_lo;
    logic [GW-1:0]         w_sel;
    logic                  w_sel_found;
    logic [GW-1:0]         w_rr_next;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_tmo;

    assign w_aw_hs = m.m_awvalid & m.m_awready;
    assign w_w_hs  = m.m_wvalid & m.m_wready;

    // Round-robin pick: lowest request at/after r_rr, else lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_hi_found && req_valid[j] && (j >= 32'(r_rr))) begin
                w_hi_found = 1'b1;
                w_hi       = GW'(j);
            end
            if (!w_lo_found && req_valid[j]) begin
                w_lo_found = 1'b1;
                w_lo       = GW'(j);
            end
        end
        w_sel       = w_hi_found ? w_hi : w_lo;
        w_sel_found = w_hi_found | w_lo_found;
        w_rr_next   = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end

`ifdef AXIL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;
    logic          w_wait_state;

    assign w_wait_state = (r_state == S_WR) || (r_state == S_WR_RESP) ||
                          (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
    assign timeout_err  = r_tmo_err;

    // Watchdog: restarts on every state change, counts while waiting.
    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (w_wait_state) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end
        end
    end
`endif

    // Next-state decode; timeout overrides a state that has not completed.
    always_comb begin
        w_state_next = r_state;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE:    if (w_sel_found) w_state_next = req_write[w_sel] ? S_WR : S_RD_ADDR;
            S_WR:      if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_next = S_WR_RESP;
            S_WR_RESP: if (m.m_bvalid) w_state_next = S_ACK;
            S_RD_ADDR: if (m.m_arready) w_state_next = S_RD_DATA;
            S_RD_DATA: if (m.m_rvalid) w_state_next = S_ACK;
            S_ACK:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
`ifdef AXIL_TIMEOUT_EN
        if (w_wait_state && (w_state_next == r_state) &&
            (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            w_state_next = S_ACK;
            w_tmo        = 1'b1;
        end
`endif
    end

    // Bus and requester outputs decoded from the registered state.
    always_comb begin
        m.m_awaddr  = r_addr;
        m.m_awprot  = 3'b000;
        m.m_awvalid = (r_state == S_WR) && !r_aw_done;
        m.m_wdata   = r_wdata;
        m.m_wstrb   = r_wstrb;
        m.m_wvalid  = (r_state == S_WR) && !r_w_done;
        m.m_bready  = (r_state == S_WR_RESP);
        m.m_araddr  = r_addr;
        m.m_arprot  = 3'b000;
        m.m_arvalid = (r_state == S_RD_ADDR);
        m.m_rready  = (r_state == S_RD_DATA);
        req_ack     = (r_state == S_ACK) ? (NUM_REQ'(1) << r_grant) : '0;
        req_rdata   = r_rdata;
        req_resp    = r_resp;
        busy        = r_busy;
    end

    // State register, command latch and response capture.
    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            r_state   <= S_IDLE;
            r_rr      <= '0;
            r_grant   <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_grant   <= w_sel;
                        r_write   <= req_write[w_sel];
                        r_addr    <= req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata   <= req_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
                        r_wstrb   <= req_wstrb[w_sel*SW +: SW];
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_WR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (m.m_bvalid) begin
                        r_resp  <= m.m_bresp;
                        r_rdata <= '0;
                    end
                end
                S_RD_DATA: begin
                    if (m.m_rvalid) begin
                        r_resp  <= m.m_rresp;
                        r_rdata <= m.m_rdata;
                    end
                end
                S_ACK: begin
                    r_busy <= 1'b0;
                    r_rr   <= w_rr_next;
                end
                default: ;
            endcase
            if (w_tmo) begin
                r_resp  <= 2'b11;
                r_rdata <= DATA_WIDTH'(32'hDEAD_BEEF);
            end
        end
    end

    logic w_unused;
    assign w_unused = r_write;
endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb_axil_req_arbiter: directed + randomized checks of the AXI-lite request
// arbiter against a pending-set/round-robin reference model and a
// configurable-latency AXI-lite slave. Timeout checks need AXIL_TIMEOUT_EN.
module tb_axil_req_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic            aclk = 1'b0;
    logic            aclk_reset;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_resp;
    logic            busy;
`ifdef AXIL_TIMEOUT_EN
    logic            timeout_err;
`endif

    axil_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_req_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk), .aclk_reset(aclk_reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_resp(req_resp),
        .m(bus), .busy(busy)
`ifdef AXIL_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic        ar_en;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_seen, w_seen, b_act, r_act;
    int          cyc = 0;
    int          n_aw_hs = 0, n_w_hs = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;
    logic          aw_hs, w_hs, ar_hs, aw_any, w_any;

    assign bus.m_awready = (aw_cnt >= aw_delay);
    assign bus.m_wready  = (w_cnt >= w_delay);
    assign bus.m_arready = ar_en && (ar_cnt >= ar_delay);
    assign bus.m_bvalid  = b_act && (b_cnt >= b_delay);
    assign bus.m_bresp   = cfg_bresp;
    assign bus.m_rvalid  = r_act && (r_cnt >= r_delay);
    assign bus.m_rdata   = cfg_rdata;
    assign bus.m_rresp   = cfg_rresp;
    assign aw_hs  = bus.m_awvalid && bus.m_awready;
    assign w_hs   = bus.m_wvalid && bus.m_wready;
    assign ar_hs  = bus.m_arvalid && bus.m_arready;
    assign aw_any = aw_seen || aw_hs;
    assign w_any  = w_seen || w_hs;

    // Slave protocol state plus handshake monitor.
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (aw_hs) begin n_aw_hs <= n_aw_hs + 1; aw_hs_cyc <= cyc; cap_awaddr <= bus.m_awaddr; end
        if (w_hs)  begin n_w_hs <= n_w_hs + 1; w_hs_cyc <= cyc; cap_wdata <= bus.m_wdata; cap_wstrb <= bus.m_wstrb; end
        if (ar_hs) cap_araddr <= bus.m_araddr;
        if (aclk_reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; b_act <= 1'b0; r_act <= 1'b0;
        end else begin
            aw_cnt <= (bus.m_awvalid && !bus.m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.m_wvalid && !bus.m_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.m_arvalid && !bus.m_arready) ? ar_cnt + 1 : 0;
            if (!b_act && aw_any && w_any) begin
                b_act <= 1'b1; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                if (aw_hs) aw_seen <= 1'b1;
                if (w_hs)  w_seen  <= 1'b1;
            end
            if (b_act) begin
                if (bus.m_bvalid && bus.m_bready) b_act <= 1'b0;
                else if (!bus.m_bvalid) b_cnt <= b_cnt + 1;
            end
            if (ar_hs) begin
                r_act <= 1'b1; r_cnt <= 0;
            end else if (r_act) begin
                if (bus.m_rvalid && bus.m_rready) r_act <= 1'b0;
                else if (!bus.m_rvalid) r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    int m_rr = 0;
    logic          cmd_wr   [N];
    logic [AW-1:0] cmd_addr [N];
    logic [DW-1:0] cmd_data [N];
    logic [SW-1:0] cmd_strb [N];

    function automatic int exp_grant(input logic [N-1:0] pend, input int rr);
        for (int k = 0; k < N; k++) begin
            if (pend[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_wr[i] = wr; cmd_addr[i] = a; cmd_data[i] = d; cmd_strb[i] = s;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_ack(input int budget, output int idx, output int lat,
                            output logic [N-1:0] vec);
        idx = -1; lat = 0; vec = '0;
        for (int c = 1; c <= budget && idx < 0; c++) begin
            @(posedge aclk); #1;
            if (req_ack != '0) begin
                vec = req_ack; lat = c;
                for (int k = 0; k < N; k++) if (req_ack[k]) idx = k;
            end
        end
        check("ack_arrived", (idx >= 0), 1'b1);
    endtask

    // Checks one completed transaction of requester g against its command.
    task automatic check_txn(input string tag, input int idx, input logic [N-1:0] vec,
                             input int g, input logic [1:0] resp_exp, input logic [DW-1:0] rd_exp);
        check({tag, "_grant"}, idx, g);
        check({tag, "_onehot"}, vec, N'(1) << g);
        check({tag, "_resp"}, req_resp, resp_exp);
        if (cmd_wr[g]) begin
            check({tag, "_rdata_wr"}, req_rdata, '0);
            check({tag, "_awaddr"}, cap_awaddr, cmd_addr[g]);
            check({tag, "_wdata"}, {cap_wstrb, cap_wdata}, {cmd_strb[g], cmd_data[g]});
        end else begin
            check({tag, "_rdata"}, req_rdata, rd_exp);
            check({tag, "_araddr"}, cap_araddr, cmd_addr[g]);
        end
    endtask

    task automatic do_reset(input int cycles);
        aclk_reset = 1'b1;
        repeat (cycles) @(posedge aclk);
        #1 aclk_reset = 1'b0;
        m_rr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, lat, aw0, w0, g, n_ack_bad;
        logic [N-1:0] vec, pend;
        logic got_rready;

        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        ar_en = 1'b1; cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
        for (int i = 0; i < N; i++) begin
            cmd_wr[i] = 1'b0; cmd_addr[i] = '0; cmd_data[i] = '0; cmd_strb[i] = '0;
        end
        do_reset(3);

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_ack", req_ack, '0);
        check("rst_rdata_resp", {req_rdata, req_resp}, '0);
        check("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready}, '0);
        check("rst_addr", {bus.m_awaddr, bus.m_wdata}, '0);
        check("prot_tied", {bus.m_awprot, bus.m_arprot}, '0);

        // Req0 write, zero-wait slave, latency and command latch
        drive_cmd(0, 1'b1, 11'h010, 32'h1234_5678, 4'hF);
        @(posedge aclk); #1;
        check("wr_busy_after_grant", busy, 1'b1);
        check("wr_awvalid_wvalid", {bus.m_awvalid, bus.m_wvalid}, 2'b11);
        req_addr[0 +: AW] = 11'h7FF;
        req_wdata[0 +: DW] = 32'h0;
        wait_ack(20, idx, lat, vec);
        check("wr_grant_to_ack_cycles", 2 + lat, 4);
        check_txn("wr0", idx, vec, 0, 2'b00, '0);
        check("wr_aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);
        m_rr = 1;
        req_valid[0] = 1'b0;
        @(posedge aclk); #1;
        check("wr_ack_one_cycle", req_ack, '0);
        check("wr_busy_cleared", busy, 1'b0);

        // Req2 read, slave data after 5 cycles, valid dropped mid-transaction
        r_delay = 5; cfg_rdata = 32'hCAFE_0001;
        drive_cmd(2, 1'b0, 11'h0F0, '0, '0);
        @(posedge aclk); #1;
        check("rd_arvalid_after_grant", bus.m_arvalid, 1'b1);
        req_valid[2] = 1'b0;
        wait_ack(40, idx, lat, vec);
        check_txn("rd2", idx, vec, 2, 2'b00, 32'hCAFE_0001);
        m_rr = 3;
        @(posedge aclk); #1;

        // All four held from reset: round-robin order with idle cycle between
        do_reset(2);
        r_delay = 0; cfg_rdata = $urandom;
        for (int i = 0; i < N; i++)
            drive_cmd(i, (i % 2) == 0, AW'($urandom), $urandom, SW'($urandom));
        for (int t = 0; t < 5; t++) begin
            g = exp_grant('1, m_rr);
            wait_ack(20, idx, lat, vec);
            check_txn($sformatf("rr%0d", t), idx, vec, g, 2'b00, cfg_rdata);
            m_rr = (g + 1) % N;
            @(posedge aclk); #1;
            check($sformatf("rr%0d_ack_width", t), req_ack, '0);
            check($sformatf("rr%0d_no_grant_in_ack", t), {busy, bus.m_awvalid, bus.m_arvalid}, '0);
        end
        req_valid = '0;
        @(posedge aclk); #1;

        // Write with W 3 cycles ahead of AW, then AW 3 cycles ahead of W
        for (int pass = 0; pass < 2; pass++) begin
            aw_delay  = (pass == 0) ? 3 : 0;
            w_delay   = (pass == 0) ? 0 : 3;
            cfg_bresp = (pass == 0) ? 2'b10 : 2'b01;
            aw0 = n_aw_hs; w0 = n_w_hs;
            drive_cmd(1, 1'b1, AW'($urandom), $urandom, SW'($urandom));
            g = exp_grant(4'b0010, m_rr);
            wait_ack(30, idx, lat, vec);
            check_txn($sformatf("ord%0d", pass), idx, vec, g, cfg_bresp, '0);
            check($sformatf("ord%0d_hs_count", pass), {n_aw_hs - aw0, n_w_hs - w0}, {32'd1, 32'd1});
            check($sformatf("ord%0d_hs_skew", pass),
                  (pass == 0) ? (aw_hs_cyc - w_hs_cyc) : (w_hs_cyc - aw_hs_cyc), 3);
            m_rr = (g + 1) % N;
            req_valid[1] = 1'b0;
            @(posedge aclk); #1;
        end
        aw_delay = 0; w_delay = 0; cfg_bresp = 2'b00;

        // Reset while in RD_DATA, then a normal read
        r_delay = 10;
        drive_cmd(3, 1'b0, 11'h155, '0, '0);
        got_rready = 1'b0;
        for (int c = 0; c < 20 && !got_rready; c++) begin
            @(posedge aclk); #1;
            got_rready = bus.m_rready;
        end
        check("mid_rst_reached_rd_data", got_rready, 1'b1);
        aclk_reset = 1'b1;
        req_valid = '0;
        @(posedge aclk); #1;
        check("mid_rst_bus_idle", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready}, '0);
        check("mid_rst_busy_ack", {busy, req_ack}, '0);
        aclk_reset = 1'b0;
        m_rr = 0;
        n_ack_bad = 0;
        repeat (4) begin
            @(posedge aclk); #1;
            if (req_ack != '0) n_ack_bad++;
        end
        check("mid_rst_no_ack", n_ack_bad, 0);
        r_delay = 1; cfg_rdata = 32'h0BAD_F00D;
        drive_cmd(3, 1'b0, 11'h2A0, '0, '0);
        g = exp_grant(4'b1000, m_rr);
        wait_ack(20, idx, lat, vec);
        check_txn("post_rst_rd", idx, vec, g, 2'b00, cfg_rdata);
        m_rr = (g + 1) % N;
        req_valid = '0;
        @(posedge aclk); #1;

        // Randomized rounds: random requester sets, commands and slave latency
        for (int r = 0; r < 8; r++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom); cfg_rdata = $urandom;
            for (int i = 0; i < N; i++)
                if (pend[i]) drive_cmd(i, 1'($urandom), AW'($urandom), $urandom, SW'($urandom));
            while (pend != '0) begin
                g = exp_grant(pend, m_rr);
                wait_ack(40, idx, lat, vec);
                check_txn($sformatf("rnd%0d_g%0d", r, g), idx, vec, g,
                          cmd_wr[g] ? cfg_bresp : cfg_rresp, cfg_rdata);
                m_rr = (g + 1) % N;
                pend[g] = 1'b0;
                req_valid[g] = 1'b0;
                if (idx < 0) pend = '0;
            end
            @(posedge aclk); #1;
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;

`ifdef AXIL_TIMEOUT_EN
        // Slave never accepts AR: watchdog aborts after TMO cycles in RD_ADDR
        check("tmo_err_clear", timeout_err, 1'b0);
        ar_en = 1'b0;
        drive_cmd(0, 1'b0, 11'h044, '0, '0);
        g = exp_grant(4'b0001, m_rr);
        wait_ack(60, idx, lat, vec);
        check("tmo_latency", lat, 1 + TMO);
        check("tmo_grant", idx, g);
        check("tmo_resp_rdata", {req_resp, req_rdata}, {2'b11, 32'hDEAD_BEEF});
        check("tmo_err_set", timeout_err, 1'b1);
        m_rr = (g + 1) % N;
        req_valid = '0;
        ar_en = 1'b1;
        @(posedge aclk); #1;
        check("tmo_arvalid_dropped", bus.m_arvalid, 1'b0);
        cfg_rdata = 32'h1357_9BDF;
        drive_cmd(1, 1'b0, 11'h300, '0, '0);
        g = exp_grant(4'b0010, m_rr);
        wait_ack(20, idx, lat, vec);
        check_txn("tmo_after_rd", idx, vec, g, 2'b00, cfg_rdata);
        check("tmo_err_sticky", timeout_err, 1'b1);
        req_valid = '0;
        @(posedge aclk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
